stream_mux: RTL

Parametrised, registered N-channel, W-bit multiplexer with valid/ready handshakes on every input and on the output. It is the sequential successor to the Hack-platform 2:1 Mux. It selects one of CHANNELS input streams, either by an explicit select input or by round-robin arbitration, and presents the chosen word through a single-entry output register. It sits between multiple word producers (for example memory-mapped peripherals) and a single consumer bus.

---
 rtl/stream_mux_pkg.sv | 11 +
 rtl/stream_mux_rr_pick.sv | 33 +++
 rtl/stream_mux.sv | 101 ++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared constants for the stream multiplexer.
// The mode encodings and default geometry are used by stream_mux and rr_pick.
package stream_mux_pkg;

  localparam logic MODE_SELECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam int DEFAULT_WIDTH    = 16;
  localparam int DEFAULT_CHANNELS = 4;

endpackage

// File: rtl/stream_mux_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester at or above ptr (wrapping).
// Only compiled when STREAM_MUX_RR_EN is defined; the select-only build has no ptr state.
`ifdef STREAM_MUX_RR_EN
module rr_pick
  import stream_mux_pkg::*;
#(
  parameter int  CHANNELS = DEFAULT_CHANNELS,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    grant,
  output logic                grant_valid
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % CHANNELS;
      if (req[idx]) begin
        grant       = SEL_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/stream_mux.sv
// stream_mux: registered N-way stream multiplexer with valid/ready on every port.
// Round-robin arbitration (mode = 1) is compiled in only when STREAM_MUX_RR_EN is defined.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int  WIDTH    = DEFAULT_WIDTH,
  parameter int  CHANNELS = DEFAULT_CHANNELS,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);

  logic             load;
  logic             take;
  logic             grant_valid;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] grant_word;

  assign load = !out_valid || out_ready;

`ifdef STREAM_MUX_RR_EN
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_valid;

  rr_pick #(.CHANNELS(CHANNELS)) u_rr_pick (
    .req         (in_valid),
    .ptr         (ptr),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  always_comb begin
    if (mode == MODE_RR) begin
      grant       = rr_grant;
      grant_valid = rr_valid;
    end else begin
      grant       = sel;
      grant_valid = (int'(sel) < CHANNELS);
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    grant       = sel;
    grant_valid = (int'(sel) < CHANNELS);
  end
`endif

  // Select mode offers ready without looking at in_valid; only RR couples them.
  always_comb begin
    in_ready = '0;
    if (!reset && load && grant_valid) in_ready[grant] = 1'b1;
  end

  always_comb begin
    grant_word = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (i == int'(grant)) grant_word = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign take = |(in_valid & in_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= grant_word;
      out_chan  <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef STREAM_MUX_RR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (take && mode == MODE_RR) begin
      ptr <= (int'(grant) == CHANNELS - 1) ? '0 : grant + SEL_W'(1);
    end
  end
`endif

endmodule
